coin_acceptor: RTL
==================

# coin_acceptor

Payment front end for the washing-machine controller. Accumulates coin credit and selects single or double wash. When credit covers the price and the controller is idle, it issues a one-cycle `coin` start pulse and a latched `double_wash` level to the controller, then returns change. It also handles cancel/refund, rejects coins while a cycle runs, and re-arms on `wash_done`.

## Interface
- CREDIT_W, 8, credit/refund width in currency units
- PRICE_SINGLE, 20, price of single wash
- PRICE_DOUBLE, 30, price of double wash
- MAX_CREDIT, 200, highest credit accepted; must be < 2^CREDIT_W and ≥ PRICE_DOUBLE
- clk  in  1  single clock for all state
- reset  in  1  synchronous, active-high; clears all state and outputs at the next clk edge
- coin_valid  in  1  one-cycle pulse, a coin was inserted
- coin_value  in  2  denomination: 00=1, 01=5, 10=10, 11=25 units
- double_req  in  1  user selects double wash (level)
- cancel  in  1  one-cycle pulse, user requests refund
- busy  in  1  controller not in IDLE
- wash_done  in  1  one-cycle pulse from controller at cycle end
- coin  out  1  start pulse to controller
- double_wash  out  1  latched wash mode for the running cycle
- credit  out  CREDIT_W  current credit (display)
- refund_valid  out  1  one-cycle pulse, dispense refund_amount
- refund_amount  out  CREDIT_W  amount to dispense; valid only with refund_valid, 0 otherwise
- coin_reject  out  1  one-cycle pulse, the last coin is returned and not credited

## Operation
- States: IDLE, COLLECT, START, RUN, REFUND. All outputs are registered; `coin` is 1 only in START.
- IDLE: credit=0. An accepted coin adds its value to credit -> COLLECT.
- COLLECT:
  - Each accepted coin adds its value to credit.
  - price = double_req ? PRICE_DOUBLE : PRICE_SINGLE, evaluated every cycle on the registered credit.
  - If cancel -> REFUND. cancel has priority over a coin in the same cycle; that coin is rejected.
  - Else if credit ≥ price and busy=0 -> START. double_req is sampled into double_wash on this same edge.
  - A coin arriving on the transition cycle is rejected.
- START, one cycle:
  - coin=1.
  - credit becomes 0.
  - If credit−price > 0: refund_valid=1 and refund_amount=credit−price, in the same cycle as coin.
  - Next state RUN.
- RUN: wait for wash_done -> IDLE. double_wash stays held until then and clears to 0 on the exit edge. busy is not checked in RUN.
- REFUND, one cycle: refund_valid=1, refund_amount=credit (the value held entering REFUND), credit becomes 0 -> IDLE.
- Coin acceptance and rejection:
  - Arithmetic is CREDIT_W+1 bits.
  - A coin is rejected if credit+value > MAX_CREDIT, or if the state is START, RUN or REFUND.
  - A rejected coin leaves credit unchanged and sets coin_reject=1 on the following cycle.
- cancel in IDLE, START, RUN or REFUND is ignored.
- wash_done outside RUN is ignored.

## Timing
- Reset values: state=IDLE, credit=0, coin=0, double_wash=0, refund_valid=0, refund_amount=0, coin_reject=0. Reset mid-cycle discards credit with no refund pulse.
- coin_valid at edge n -> credit updated at n+1.
- Threshold-to-start latency:
  - Credit reaching price at n+1 -> state START at n+2 (if busy=0), with coin=1 during n+2..n+3.
  - Minimum 2 cycles from the final coin to the coin pulse.
- coin_reject is asserted exactly 1 cycle after the offending coin_valid.
- The refund pulse is exactly 1 cycle wide. Only one refund occurs per START or REFUND entry.
- With busy=1 in COLLECT, credit keeps accumulating up to MAX_CREDIT. START fires on the first cycle busy=0 with credit ≥ price.
- double_req changes after the START transition do not affect double_wash.

## Test plan
- Single wash, exact coins: coins 10, 10, double_req=0 -> coin pulse, double_wash=0, no refund_valid, credit=0, state RUN. Then wash_done -> IDLE.
- Single wash with change: one 25 coin, double_req=0 -> coin pulse 2 cycles after credit update, with refund_valid=1 and refund_amount=5 in the same cycle.
- Double wash with change: coins 25, 10, double_req=1 -> double_wash=1, refund_amount=5. double_wash is held through RUN and clears after wash_done.
- Cancel: coins 10, 5, then cancel -> refund_valid=1 with refund_amount=15, credit=0, no coin pulse. Cancel with a simultaneous coin -> that coin is rejected.
- Overflow and busy: busy=1, eight 25 coins -> credit=200. A ninth coin -> coin_reject the next cycle, credit stays 200. Drop busy -> coin pulse, refund_amount=180.
- Coins rejected while running, and reset: a coin in RUN -> coin_reject, credit 0. Reset asserted in COLLECT with credit=15 -> all outputs 0, state IDLE, no refund pulse.

Source files
------------

// File: rtl/coin_acceptor.sv
// coin_acceptor: payment front end for the washing-machine controller.
// Accumulates coin credit, starts a single or double wash once the price is
// covered and the controller is idle, returns change, and handles cancel/refund.
module coin_acceptor #(
    parameter int CREDIT_W     = 8,
    parameter int PRICE_SINGLE = 20,
    parameter int PRICE_DOUBLE = 30,
    parameter int MAX_CREDIT   = 200
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_value,
    input  logic                double_req,
    input  logic                cancel,
    input  logic                busy,
    input  logic                wash_done,
    output logic                coin,
    output logic                double_wash,
    output logic [CREDIT_W-1:0] credit,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amount,
    output logic                coin_reject
);

    localparam int SUM_W = CREDIT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_START,
        S_RUN,
        S_REFUND
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                coin_q, coin_d;
    logic                dwash_q, dwash_d;
    logic                rvalid_q, rvalid_d;
    logic [CREDIT_W-1:0] ramt_q, ramt_d;
    logic                reject_q, reject_d;

    logic [SUM_W-1:0]    coin_units;
    logic [SUM_W-1:0]    sum;
    logic [CREDIT_W-1:0] price;
    logic                fits;
    logic                can_start;

    // Decode denomination and evaluate price/overflow on the registered credit.
    always_comb begin
        case (coin_value)
            2'b00:   coin_units = SUM_W'(1);
            2'b01:   coin_units = SUM_W'(5);
            2'b10:   coin_units = SUM_W'(10);
            default: coin_units = SUM_W'(25);
        endcase
        sum       = {1'b0, credit_q} + coin_units;
        fits      = (sum <= SUM_W'(MAX_CREDIT));
        price     = double_req ? CREDIT_W'(PRICE_DOUBLE) : CREDIT_W'(PRICE_SINGLE);
        can_start = (credit_q >= price) && !busy;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        coin_d   = 1'b0;
        dwash_d  = dwash_q;
        rvalid_d = 1'b0;
        ramt_d   = '0;
        reject_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (coin_valid) begin
                    if (fits) begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = S_COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_COLLECT: begin
                if (cancel) begin
                    state_d  = S_REFUND;
                    rvalid_d = 1'b1;
                    ramt_d   = credit_q;
                    credit_d = '0;
                    reject_d = coin_valid;
                end else if (can_start) begin
                    state_d  = S_START;
                    coin_d   = 1'b1;
                    dwash_d  = double_req;
                    credit_d = '0;
                    reject_d = coin_valid;
                    if (credit_q > price) begin
                        rvalid_d = 1'b1;
                        ramt_d   = credit_q - price;
                    end
                end else if (coin_valid) begin
                    if (fits) begin
                        credit_d = sum[CREDIT_W-1:0];
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_START: begin
                state_d  = S_RUN;
                reject_d = coin_valid;
            end
            S_RUN: begin
                reject_d = coin_valid;
                if (wash_done) begin
                    state_d = S_IDLE;
                    dwash_d = 1'b0;
                end
            end
            S_REFUND: begin
                state_d  = S_IDLE;
                reject_d = coin_valid;
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
                dwash_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            coin_q   <= 1'b0;
            dwash_q  <= 1'b0;
            rvalid_q <= 1'b0;
            ramt_q   <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            coin_q   <= coin_d;
            dwash_q  <= dwash_d;
            rvalid_q <= rvalid_d;
            ramt_q   <= ramt_d;
            reject_q <= reject_d;
        end
    end

    assign coin          = coin_q;
    assign double_wash   = dwash_q;
    assign credit        = credit_q;
    assign refund_valid  = rvalid_q;
    assign refund_amount = ramt_q;
    assign coin_reject   = reject_q;

endmodule
